// File: rtl/apb_master.sv
// APB4 initiator: turns a valid/ready request into a single APB transfer,
// with wait states, PSLVERR reporting and an optional PREADY stall timeout.
module apb_master #(
  parameter int AW          = 16,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            iPCLK,
  input  logic            iPRESET,
  input  logic            iREQ_VALID,
  output logic            oREQ_READY,
  input  logic            iREQ_WRITE,
  input  logic [AW-1:0]   iREQ_ADDR,
  input  logic [DW-1:0]   iREQ_WDATA,
  input  logic [DW/8-1:0] iREQ_STRB,
  output logic            oRSP_VALID,
  output logic [DW-1:0]   oRSP_RDATA,
  output logic            oRSP_ERR,
  output logic            oRSP_TIMEOUT,
  output logic            oPSEL,
  output logic            oPENABLE,
  output logic            oPWRITE,
  output logic [AW-1:0]   oPADDR,
  output logic [DW-1:0]   oPWDATA,
  output logic [DW/8-1:0] oPSTRB,
  input  logic [DW-1:0]   iPRDATA,
  input  logic            iPREADY,
  input  logic            iPSLVERR
);

  localparam int         SW     = DW / 8;
  localparam bit         TO_EN  = (TIMEOUT_CYC != 0);
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state_q, state_d;
  logic            pwrite_q, pwrite_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [SW-1:0]   pstrb_q, pstrb_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_to_q, rsp_to_d;

  always_ff @(posedge iPCLK or posedge iPRESET) begin
    if (iPRESET) begin
      state_q     <= IDLE;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    case (state_q)
      IDLE: begin
        if (iREQ_VALID) begin
          pwrite_d = iREQ_WRITE;
          paddr_d  = iREQ_ADDR;
          // APB4: reads drive zero strobes; write data keeps its old value on reads
          pstrb_d  = iREQ_WRITE ? iREQ_STRB : '0;
          if (iREQ_WRITE) pwdata_d = iREQ_WDATA;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // Once the stall budget is spent the abort wins, even over a late PREADY
        if (TO_EN && cnt_q == TO_LIM) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
        end else if (iPREADY) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : iPRDATA;
          rsp_err_d   = iPSLVERR;
          rsp_to_d    = 1'b0;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign oREQ_READY   = (state_q == IDLE);
  assign oPSEL        = (state_q != IDLE);
  assign oPENABLE     = (state_q == ACCESS);
  assign oPWRITE      = pwrite_q;
  assign oPADDR       = paddr_q;
  assign oPWDATA      = pwdata_q;
  assign oPSTRB       = pstrb_q;
  assign oRSP_VALID   = rsp_valid_q;
  assign oRSP_RDATA   = rsp_rdata_q;
  assign oRSP_ERR     = rsp_err_q;
  assign oRSP_TIMEOUT = rsp_to_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: memory-backed APB responder with programmable waits,
// errors and stalls, checked against a word-array model of expected results.
module tb_apb_master;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          iPCLK = 1'b0;
  logic          iPRESET = 1'b1;
  logic          iREQ_VALID = 1'b0, iREQ_WRITE = 1'b0;
  logic [AW-1:0] iREQ_ADDR = '0;
  logic [DW-1:0] iREQ_WDATA = '0;
  logic [3:0]    iREQ_STRB = '0;
  logic          oREQ_READY, oRSP_VALID, oRSP_ERR, oRSP_TIMEOUT;
  logic [DW-1:0] oRSP_RDATA;
  logic          oPSEL, oPENABLE, oPWRITE;
  logic [AW-1:0] oPADDR;
  logic [DW-1:0] oPWDATA;
  logic [3:0]    oPSTRB;
  logic [DW-1:0] iPRDATA = '0;
  logic          iPREADY = 1'b0, iPSLVERR = 1'b0;

  apb_master #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
    .iPCLK(iPCLK), .iPRESET(iPRESET),
    .iREQ_VALID(iREQ_VALID), .oREQ_READY(oREQ_READY), .iREQ_WRITE(iREQ_WRITE),
    .iREQ_ADDR(iREQ_ADDR), .iREQ_WDATA(iREQ_WDATA), .iREQ_STRB(iREQ_STRB),
    .oRSP_VALID(oRSP_VALID), .oRSP_RDATA(oRSP_RDATA), .oRSP_ERR(oRSP_ERR),
    .oRSP_TIMEOUT(oRSP_TIMEOUT), .oPSEL(oPSEL), .oPENABLE(oPENABLE),
    .oPWRITE(oPWRITE), .oPADDR(oPADDR), .oPWDATA(oPWDATA), .oPSTRB(oPSTRB),
    .iPRDATA(iPRDATA), .iPREADY(iPREADY), .iPSLVERR(iPSLVERR)
  );

  always #5 iPCLK = ~iPCLK;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responder: PREADY after cur_wait low ACCESS cycles, never if stuck
  int          cur_wait = 0;
  bit          cur_err = 0, stuck = 0;
  int          acc_cnt = 0;
  logic [31:0] rmem [16];
  logic [31:0] ref_mem [16];

  always @(negedge iPCLK) begin
    if (oPSEL && oPENABLE && !stuck && acc_cnt >= cur_wait) begin
      iPREADY  = 1'b1;
      iPRDATA  = oPWRITE ? 32'($urandom) : rmem[oPADDR[5:2]];
      iPSLVERR = cur_err;
    end else begin
      iPREADY  = 1'b0;
      iPRDATA  = 32'($urandom);
      iPSLVERR = 1'($urandom);
    end
  end

  always @(posedge iPCLK) begin
    if (iPRESET) begin
      acc_cnt <= 0;
      if (!oPSEL) for (int i = 0; i < 16; i++) rmem[i] <= '0;
    end else if (oPSEL && oPENABLE) begin
      acc_cnt <= iPREADY ? 0 : acc_cnt + 1;
      if (iPREADY && oPWRITE)
        for (int b = 0; b < 4; b++)
          if (oPSTRB[b]) rmem[oPADDR[5:2]][8*b +: 8] <= oPWDATA[8*b +: 8];
    end else begin
      acc_cnt <= 0;
    end
  end

  task automatic scramble_req();
    iREQ_VALID = 1'($urandom);
    iREQ_WRITE = 1'($urandom);
    iREQ_ADDR  = 16'($urandom);
    iREQ_WDATA = 32'($urandom);
    iREQ_STRB  = 4'($urandom);
  endtask

  task automatic xfer(input string tag, input bit wr, input logic [15:0] addr,
                      input logic [31:0] wd, input logic [3:0] st, input int w,
                      input bit err, input bit stk, output logic [31:0] rd);
    int n = 0, ps = 0, pe = 0, exp_n;
    bit stable = 1, got = 0, completes;
    logic [31:0] exp_rd;
    cur_wait = w; cur_err = err; stuck = stk;
    @(negedge iPCLK);
    iREQ_VALID = 1'b1; iREQ_WRITE = wr; iREQ_ADDR = addr; iREQ_WDATA = wd; iREQ_STRB = st;
    @(posedge iPCLK); #1;
    scramble_req();
    while (n < 200) begin
      if (oRSP_VALID) begin got = 1; iREQ_VALID = 1'b0; break; end
      if (oPSEL) begin
        ps++;
        if (oPADDR !== addr || oPWRITE !== wr || oPSTRB !== (wr ? st : 4'h0) ||
            (wr && oPWDATA !== wd)) stable = 0;
      end
      if (oPENABLE) pe++;
      @(posedge iPCLK); #1;
      n++;
      scramble_req();
    end
    iREQ_VALID = 1'b0;
    chk({tag, ".seen"}, got, 1);
    completes = !stk && (w < TO);
    exp_n = completes ? 2 + w : 2 + TO;
    chk({tag, ".lat"}, n, exp_n);
    chk({tag, ".psel_cyc"}, ps, exp_n);
    chk({tag, ".pen_cyc"}, pe, exp_n - 1);
    chk({tag, ".stable"}, stable, 1);
    chk({tag, ".rdy"}, oREQ_READY, 1);
    chk({tag, ".gap"}, oPSEL, 0);
    if (completes) begin
      exp_rd = wr ? 32'h0 : ref_mem[addr[5:2]];
      chk({tag, ".err"}, oRSP_ERR, err);
      chk({tag, ".to"}, oRSP_TIMEOUT, 0);
      chk({tag, ".rdata"}, oRSP_RDATA, exp_rd);
      if (wr)
        for (int b = 0; b < 4; b++)
          if (st[b]) ref_mem[addr[5:2]][8*b +: 8] = wd[8*b +: 8];
    end else begin
      chk({tag, ".err"}, oRSP_ERR, 1);
      chk({tag, ".to"}, oRSP_TIMEOUT, 1);
      chk({tag, ".rdata"}, oRSP_RDATA, 0);
    end
    rd = oRSP_RDATA;
    @(posedge iPCLK); #1;
    chk({tag, ".pulse"}, oRSP_VALID, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    bit wr, stk, er, rsp_seen;
    int w, idx;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    #2;
    chk("rst.psel", oPSEL, 0);
    chk("rst.pen", oPENABLE, 0);
    chk("rst.pctl", {oPWRITE, oPADDR, oPWDATA, oPSTRB}, 0);
    chk("rst.rsp", {oRSP_VALID, oRSP_ERR, oRSP_TIMEOUT, oRSP_RDATA}, 0);
    @(negedge iPCLK); @(negedge iPCLK);
    iPRESET = 1'b0;
    #1 chk("rst.rdy", oREQ_READY, 1);

    xfer("w0", 1, 16'h0000, 32'h12345678, 4'hF, 0, 0, 0, rd);
    xfer("r0", 0, 16'h0000, 32'h0, 4'hF, 0, 0, 0, rd);
    chk("r0.val", rd, 32'h12345678);
    xfer("pw1", 1, 16'h0000, 32'hFFFFFFFF, 4'b0010, 0, 0, 0, rd);
    xfer("pr1", 0, 16'h0000, 32'h0, 4'h0, 0, 0, 0, rd);
    chk("pr1.val", rd, 32'h1234FF78);
    xfer("pw2", 1, 16'h0000, 32'h00000000, 4'b1001, 0, 0, 0, rd);
    xfer("pr2", 0, 16'h0000, 32'h0, 4'h0, 0, 0, 0, rd);
    chk("pr2.val", rd, 32'h0034FF00);
    xfer("w3", 1, 16'h0010, 32'hA5A55A5A, 4'hF, 3, 0, 0, rd);
    xfer("r3", 0, 16'h0010, 32'h0, 4'h0, 3, 0, 0, rd);
    xfer("slverr", 0, 16'h0000, 32'h0, 4'h0, 0, 1, 0, rd);
    chk("slverr.val", rd, 32'h0034FF00);
    xfer("to_r", 0, 16'h0004, 32'h0, 4'h0, 0, 0, 1, rd);
    xfer("to_w", 1, 16'h0008, 32'hDEADBEEF, 4'hF, 0, 0, 1, rd);
    xfer("late", 0, 16'h0010, 32'h0, 4'h0, TO, 0, 0, rd);
    xfer("after", 0, 16'h0010, 32'h0, 4'h0, 0, 0, 0, rd);
    chk("after.val", rd, 32'hA5A55A5A);
    xfer("edge", 0, 16'h0010, 32'h0, 4'h0, TO - 1, 0, 0, rd);

    for (int t = 0; t < 40; t++) begin
      wr  = 1'($urandom);
      idx = $urandom_range(0, 15);
      w   = wr ? $urandom_range(0, TO - 1) : $urandom_range(0, TO + 1);
      stk = !wr && ($urandom_range(0, 7) == 0);
      er  = ($urandom_range(0, 3) == 0);
      xfer($sformatf("rnd%0d", t), wr, {10'($urandom), 4'(idx), 2'b00}, 32'($urandom),
           4'($urandom), w, er, stk, rd);
    end

    // Reset in the middle of a stalled ACCESS
    cur_wait = 0; stuck = 1;
    @(negedge iPCLK);
    iREQ_VALID = 1'b1; iREQ_WRITE = 1'b0; iREQ_ADDR = 16'h0004;
    @(posedge iPCLK); #1 iREQ_VALID = 1'b0;
    repeat (2) @(posedge iPCLK);
    #2;
    chk("mid.pen_before", oPENABLE, 1);
    iPRESET = 1'b1;
    #1;
    chk("mid.psel", oPSEL, 0);
    chk("mid.pen", oPENABLE, 0);
    rsp_seen = 0;
    repeat (2) begin @(negedge iPCLK); rsp_seen |= oRSP_VALID; end
    iPRESET = 1'b0;
    stuck = 0;
    #1 chk("mid.rdy", oREQ_READY, 1);
    repeat (4) begin @(posedge iPCLK); #1 rsp_seen |= oRSP_VALID; end
    chk("mid.norsp", rsp_seen, 0);
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    xfer("post_w", 1, 16'h0020, 32'hCAFEF00D, 4'hF, 1, 0, 0, rd);
    xfer("post_r", 0, 16'h0020, 32'h0, 4'h0, 2, 0, 0, rd);
    chk("post_r.val", rd, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_master.md
# apb_master

Synthesizable APB4 initiator that turns a simple valid/ready request port into single APB transfers with wait-state support, error reporting and a stall timeout. It sits between internal control logic (CPU bridge, sequencer, DMA descriptor engine) and APB responders such as the register block. It does the work the APB bench tasks did, but in RTL.

## Interface
Parameters:
- AW, 16, address width (iREQ_ADDR, oPADDR).
- DW, 32, data width (wdata/rdata); strobe width is DW/8.
- TIMEOUT_CYC, 16, ACCESS cycles with PREADY low before abort. 0 disables the timeout. Legal range is 0..255.

Ports:
- iPCLK  in  1  clock. All logic is on the rising edge.
- iPRESET  in  1  reset. Asynchronous, active-high.
- iREQ_VALID  in  1  request present.
- oREQ_READY  out  1  request accepted when high together with iREQ_VALID.
- iREQ_WRITE  in  1  1 = write, 0 = read.
- iREQ_ADDR  in  AW  transfer address.
- iREQ_WDATA  in  DW  write data.
- iREQ_STRB  in  DW/8  write byte strobes.
- oRSP_VALID  out  1  one-cycle completion pulse.
- oRSP_RDATA  out  DW  read data. Valid with oRSP_VALID on reads; 0 for writes.
- oRSP_ERR  out  1  PSLVERR seen at completion, or timeout.
- oRSP_TIMEOUT  out  1  transfer was aborted by the timeout.
- oPSEL, oPENABLE, oPWRITE  out  1 each  APB control.
- oPADDR  out  AW, oPWDATA  out  DW, oPSTRB  out  DW/8  APB address, data and strobes.
- iPRDATA  in  DW, iPREADY  in  1, iPSLVERR  in  1  APB response.

## Operation
- FSM has three states: IDLE, SETUP, ACCESS.
- IDLE:
  - oREQ_READY = 1; it is 1 only in IDLE.
  - On iREQ_VALID, capture write, addr, wdata and strb into the APB output registers. Go to SETUP.
- SETUP: oPSEL = 1, oPENABLE = 0. Unconditionally go to ACCESS.
- ACCESS, oPSEL = 1 and oPENABLE = 1:
  - iPREADY = 1: complete the transfer and go to IDLE.
  - iPREADY = 0: increment the wait counter. If TIMEOUT_CYC ≠ 0 and the counter reaches TIMEOUT_CYC, abort and go to IDLE.
- oPSTRB = captured strobe for writes. oPSTRB = 0 for reads (APB4 rule).
- oPWDATA is captured for writes only. On reads it holds its previous value.
- oPADDR, oPWRITE and oPSTRB stay stable from SETUP through the end of ACCESS. In IDLE they hold their last values.
- Completion:
  - Register oRSP_RDATA = iPRDATA on reads, 0 on writes.
  - Register oRSP_ERR = iPSLVERR and oRSP_TIMEOUT = 0.
  - Pulse oRSP_VALID for one cycle.
- Abort:
  - Pulse oRSP_VALID with oRSP_ERR = 1, oRSP_TIMEOUT = 1, oRSP_RDATA = 0.
  - oPSEL and oPENABLE drop at that same edge.
  - A late iPREADY is ignored.
- iPSLVERR and iPRDATA are sampled only in ACCESS with iPREADY = 1. They are ignored otherwise.
- The wait counter is 8 bits and clears on entry to SETUP. It saturates and never wraps.
- iREQ_* is ignored while oREQ_READY = 0. The requester must hold the request until it is accepted.

## Timing
- Reset values, asynchronous on iPRESET:
  - FSM = IDLE.
  - oPSEL, oPENABLE, oPWRITE, oPADDR, oPWDATA, oPSTRB = 0.
  - oRSP_* = 0.
  - oREQ_READY = 1 immediately after deassertion.
- Reset mid-transfer: oPSEL and oPENABLE go to 0 asynchronously. No response is generated.
- Request accepted at edge E0:
  - E0: oPSEL rises (SETUP).
  - E1: oPENABLE rises (ACCESS).
  - First edge Ek≥E2 with iPREADY = 1 sampled: oPSEL and oPENABLE fall, FSM returns to IDLE, oRSP_VALID = 1 for the cycle after Ek.
- Zero-wait transfer: request to response is 3 cycles.
- Back-to-back: oREQ_READY is high in the oRSP_VALID cycle. The next SETUP starts 1 cycle later, so there is at least one cycle with oPSEL = 0 between transfers.
- Timeout: with TIMEOUT_CYC = N, abort happens at the edge after N consecutive ACCESS cycles with iPREADY = 0. The transfer occupies 2 + N cycles of PSEL.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Responder with 0 wait states.
  - Write 0x0000 ← 0x12345678, strb 1111, then read 0x0000.
  - Required: PSEL high for exactly 2 cycles each; oPSTRB = 1111 on the write, 0000 on the read.
  - Required: read oRSP_RDATA = 0x12345678 with oRSP_ERR = 0; 3-cycle latency each.
- Partial write.
  - Write 0xFFFFFFFF with strb 0010, then write 0x00000000 with strb 1001, reading back after each.
  - Required: reads return 0x1234FF78, then 0x0034FF00.
- Responder with 3 wait states.
  - Required: oPENABLE is high for 4 cycles.
  - Required: oPADDR and oPWDATA stay stable throughout ACCESS; oRSP_VALID comes 6 cycles after acceptance.
- Responder returns PSLVERR = 1 with PREADY on a read.
  - Required: oRSP_ERR = 1, oRSP_TIMEOUT = 0, oRSP_RDATA = iPRDATA.
- TIMEOUT_CYC = 4 and PREADY stuck at 0.
  - Required: abort after 4 ACCESS cycles; oRSP_ERR = oRSP_TIMEOUT = 1, oRSP_RDATA = 0.
  - Required: the next request completes normally.
- Assert iPRESET during ACCESS of a waited transfer.
  - Required: oPSEL and oPENABLE drop the same cycle without waiting for a clock edge.
  - Required: no oRSP_VALID is produced; oREQ_READY = 1 after release.
